step_ctrl: RTL and testbench

//  Front end of the single-step computer. Conditions the raw STEP and MODE keys and

---
 rtl/computer_pkg.sv | 18 +
 rtl/btn_conditioner.sv | 57 +++++
 rtl/step_ctrl.sv | 129 ++++++++++++
 tb/tb_step_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/computer_pkg.sv
// Shared types and default timing constants for the single-step computer front end.
package computer_pkg;

  typedef enum logic [1:0] {
    SS   = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } step_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_50M = 1_000_000;
  localparam int unsigned RUN_DIV_4HZ         = 12_500_000;

  // Bits needed for a down-counter loaded with n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw active-low key -> synchronised, debounced, one-cycle press pulse on the 0->1
// transition of the accepted level.
module btn_conditioner
  import computer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            stable_q, stable_d;
  logic            stable_dly_q;
  logic            press_q, press_d;

  // A pending change sits in sync1 vs sync2, so the count restarts as the new level lands.
  always_comb begin
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (sync1_q != sync2_q) begin
      db_cnt_d = DB_LOAD;
    end else if (db_cnt_q != '0) begin
      db_cnt_d = db_cnt_q - 1'b1;
    end else begin
      stable_d = sync2_q;
    end
    press_d = stable_q & ~stable_dly_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= ~key_n;
      sync2_q      <= sync1_q;
      db_cnt_q     <= db_cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/step_ctrl.sv
// Single-step / free-run / breakpoint-halt controller producing one-cycle core
// clock-enable pulses from the STEP and MODE keys.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   SS    | single-step: each STEP press issues one step_en
//   RUN   | free-run: one step_en per RUN_DIV cycles, halts on breakpoint
//   HALT  | stopped at breakpoint: STEP steps out to SS, MODE resumes RUN
module step_ctrl
  import computer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50M,
  parameter int unsigned RUN_DIV         = RUN_DIV_4HZ,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step_n,
  input  logic             btn_mode_n,
  input  logic [31:0]      pc,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  output logic             step_en,
  output logic             run_active,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned PRESC_W = cnt_width(RUN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LOAD = PRESC_W'(RUN_DIV - 1);

  logic step_p, mode_p;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .clk   (clk),
    .reset (reset),
    .key_n (btn_step_n),
    .press (step_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
    .clk   (clk),
    .reset (reset),
    .key_n (btn_mode_n),
    .press (mode_p)
  );

  step_state_t        state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               bp_mask_q, bp_mask_d;
  logic               step_en_q, step_en_d;
  logic [CNT_W-1:0]   step_count_q, step_count_d;
  logic               run_active_q, halted_q;
  logic               bp_hit, presc_tc;

  assign bp_hit   = bp_en && (pc == bp_addr) && !bp_mask_q;
  assign presc_tc = (presc_q == '0);

  // Prescaler is a down-counter; loading RUN_DIV-1 is the "prescaler = 0" start point.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    bp_mask_d = bp_mask_q;
    step_en_d = 1'b0;
    case (state_q)
      SS: begin
        if (mode_p) begin
          state_d = RUN;
          presc_d = PRESC_LOAD;
        end else if (step_p) begin
          step_en_d = 1'b1;
        end
      end
      RUN: begin
        if (mode_p) begin
          state_d = SS;
        end else if (presc_tc) begin
          presc_d = PRESC_LOAD;
          if (bp_hit) begin
            state_d = HALT;
          end else begin
            step_en_d = 1'b1;
            bp_mask_d = 1'b0;
          end
        end else begin
          presc_d = presc_q - 1'b1;
        end
      end
      HALT: begin
        if (mode_p) begin
          state_d   = RUN;
          presc_d   = PRESC_LOAD;
          bp_mask_d = 1'b1;
        end else if (step_p) begin
          step_en_d = 1'b1;
          state_d   = SS;
        end
      end
      default: state_d = SS;
    endcase
    step_count_d = step_en_d ? step_count_q + 1'b1 : step_count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= SS;
      presc_q      <= '0;
      bp_mask_q    <= 1'b0;
      step_en_q    <= 1'b0;
      step_count_q <= '0;
      run_active_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      bp_mask_q    <= bp_mask_d;
      step_en_q    <= step_en_d;
      step_count_q <= step_count_d;
      run_active_q <= (state_d == RUN);
      halted_q     <= (state_d == HALT);
    end
  end

  assign step_en    = step_en_q;
  assign run_active = run_active_q;
  assign halted     = halted_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with short debounce and run divider.
module tb_step_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_step_n = 1'b1;
  logic        btn_mode_n = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic        step_en;
  logic        run_active;
  logic        halted;
  logic [3:0]  step_count;

  int errors = 0;
  int checks = 0;
  int consec = 0;
  logic step_en_prev = 1'b0;

  step_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(5), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_step_n (btn_step_n),
    .btn_mode_n (btn_mode_n),
    .pc         (pc),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .step_en    (step_en),
    .run_active (run_active),
    .halted     (halted),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (step_en && step_en_prev) consec <= consec + 1;
    step_en_prev <= step_en;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_step_en", 32'(step_en), 32'd0);
    check("rst_run", 32'(run_active), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(step_count), 32'd0);
    reset = 1'b1;
    tick(3);

    // 1. STEP with three one-cycle bounces, then held 20 cycles
    for (int b = 0; b < 3; b++) begin
      btn_step_n = 1'b0; tick(1);
      btn_step_n = 1'b1; tick(1);
    end
    btn_step_n = 1'b0;
    tick(7);
    check("t1_lat_before", 32'(step_en), 32'd0);
    tick(1);
    check("t1_lat_pulse", 32'(step_en), 32'd1);
    tick(1);
    check("t1_lat_after", 32'(step_en), 32'd0);
    tick(11);
    btn_step_n = 1'b1;
    tick(15);
    check("t1_count", 32'(step_count), 32'd1);

    // 2. Free run, bp disabled
    btn_mode_n = 1'b0;
    tick(8);
    check("t2_run_on", 32'(run_active), 32'd1);
    check("t2_no_pulse", 32'(step_en), 32'd0);
    tick(2);
    btn_mode_n = 1'b1;
    tick(24);
    check("t2_count_run", 32'(step_count), 32'd6);
    btn_mode_n = 1'b0;
    tick(8);
    check("t2_run_off", 32'(run_active), 32'd0);
    check("t2_count_exit", 32'(step_count), 32'd7);
    btn_mode_n = 1'b1;
    tick(12);
    check("t2_stopped", 32'(step_count), 32'd7);

    // 3. Breakpoint halt, then resume past it
    pc = 32'h10; bp_addr = 32'h10; bp_en = 1'b1;
    btn_mode_n = 1'b0;
    tick(8);
    check("t3_run_on", 32'(run_active), 32'd1);
    tick(5);
    check("t3_halted", 32'(halted), 32'd1);
    check("t3_run_off", 32'(run_active), 32'd0);
    check("t3_no_pulse", 32'(step_en), 32'd0);
    check("t3_count", 32'(step_count), 32'd7);
    btn_mode_n = 1'b1;
    tick(12);
    btn_mode_n = 1'b0;
    tick(8);
    check("t3_resume", 32'(run_active), 32'd1);
    check("t3_unhalt", 32'(halted), 32'd0);
    tick(5);
    check("t3_masked_pulse", 32'(step_en), 32'd1);
    check("t3_masked_count", 32'(step_count), 32'd8);
    tick(5);
    check("t3_rehalt", 32'(halted), 32'd1);
    check("t3_rehalt_count", 32'(step_count), 32'd8);
    btn_mode_n = 1'b1;
    tick(12);

    // 4. STEP out of HALT
    btn_step_n = 1'b0;
    tick(7);
    check("t4_still_halt", 32'(halted), 32'd1);
    tick(1);
    check("t4_pulse", 32'(step_en), 32'd1);
    check("t4_halted", 32'(halted), 32'd0);
    check("t4_run", 32'(run_active), 32'd0);
    check("t4_count", 32'(step_count), 32'd9);
    btn_step_n = 1'b1;
    tick(12);

    // 5. STEP and MODE on the same cycle: MODE wins
    bp_en = 1'b0;
    btn_step_n = 1'b0; btn_mode_n = 1'b0;
    tick(8);
    check("t5_run", 32'(run_active), 32'd1);
    check("t5_no_pulse", 32'(step_en), 32'd0);
    check("t5_count", 32'(step_count), 32'd9);
    btn_step_n = 1'b1; btn_mode_n = 1'b1;
    tick(10);
    btn_mode_n = 1'b0;
    tick(8);
    check("t5_exit", 32'(run_active), 32'd0);
    check("t5_exit_count", 32'(step_count), 32'd12);
    btn_mode_n = 1'b1;
    tick(12);
    check("no_consecutive", 32'(consec), 32'd0);

    // 6. Counter wrap after 17 steps from reset
    reset = 1'b0;
    tick(2);
    check("t6_rst_count", 32'(step_count), 32'd0);
    reset = 1'b1;
    tick(2);
    for (int s = 0; s < 16; s++) begin
      btn_step_n = 1'b0; tick(10);
      btn_step_n = 1'b1; tick(10);
    end
    check("t6_count16", 32'(step_count), 32'd0);
    btn_step_n = 1'b0; tick(10);
    btn_step_n = 1'b1; tick(10);
    check("t6_count17", 32'(step_count), 32'd1);

    // Reset asserted while a RUN pulse is high
    btn_mode_n = 1'b0;
    tick(8);
    check("t6_run", 32'(run_active), 32'd1);
    tick(5);
    check("t6_pulse", 32'(step_en), 32'd1);
    check("t6_pulse_count", 32'(step_count), 32'd2);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_step_en", 32'(step_en), 32'd0);
    check("t6_rst_run", 32'(run_active), 32'd0);
    check("t6_rst_halted", 32'(halted), 32'd0);
    check("t6_rst_cnt", 32'(step_count), 32'd0);
    btn_mode_n = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
